// File: rtl/envelope_gain_stage.sv
// Per-voice ADSR envelope and gain stage: a sample-rate ADSR FSM scales the player stream
// into one signed 16-bit output sample per sample period.
//
// state   | meaning
// IDLE    | silent, level held at 0
// ATTACK  | level rising by attack_step toward full scale
// DECAY   | level falling by decay_step toward sustain_level
// SUSTAIN | level follows sustain_level while gate is held
// RELEASE | level falling by release_step toward 0 after gate drops
module envelope_gain_stage #(
    parameter int MCLK_PER_SAMPLE = 256,
    parameter int LEVEL_BITS      = 16
) (
    input  logic                    mclk,
    input  logic                    rst_n,
    input  logic signed [15:0]      in_sample,
    input  logic                    in_valid,
    input  logic                    gate,
    input  logic [LEVEL_BITS-1:0]   attack_step,
    input  logic [LEVEL_BITS-1:0]   decay_step,
    input  logic [LEVEL_BITS-1:0]   sustain_level,
    input  logic [LEVEL_BITS-1:0]   release_step,
    output logic signed [15:0]      out_sample,
    output logic                    out_valid,
    output logic [LEVEL_BITS-1:0]   env_level,
    output logic [2:0]              env_state,
    output logic                    busy
);

    localparam int CNT_BITS = (MCLK_PER_SAMPLE > 2) ? $clog2(MCLK_PER_SAMPLE) : 1;
    localparam logic [CNT_BITS-1:0]   CNT_LAST = CNT_BITS'(MCLK_PER_SAMPLE - 1);
    localparam logic [LEVEL_BITS-1:0] FS       = '1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t                  state, state_nxt;
    logic [CNT_BITS-1:0]     cnt;
    logic                    tick;
    logic                    gate_d, rise, rise_seen;
    logic [LEVEL_BITS-1:0]   level_nxt, atk_level, rel_level;
    logic [LEVEL_BITS:0]     atk_sum, dec_thr;
    logic                    atk_full, dec_done, rel_done;
    logic signed [15:0]      smp;
    logic signed [LEVEL_BITS+16:0] lvl_w, smp_w;

    assign tick      = (cnt == CNT_LAST);
    assign rise      = gate & ~gate_d;
    assign env_state = state;
    assign busy      = (state != S_IDLE);

    // Sums are one bit wider so a large step saturates instead of wrapping.
    assign atk_sum   = {1'b0, env_level} + {1'b0, attack_step};
    assign atk_full  = (attack_step == '0) || (atk_sum >= {1'b0, FS});
    assign atk_level = atk_full ? FS : atk_sum[LEVEL_BITS-1:0];
    assign dec_thr   = {1'b0, sustain_level} + {1'b0, decay_step};
    assign dec_done  = (decay_step == '0) || ({1'b0, env_level} <= dec_thr);
    assign rel_done  = (release_step == '0) || (env_level <= release_step);
    assign rel_level = rel_done ? '0 : env_level - release_step;

    always_comb begin
        state_nxt = state;
        level_nxt = env_level;
        if (rise_seen || rise) begin
            // Retrigger is legato: attack resumes from the current level.
            state_nxt = S_ATTACK;
            level_nxt = atk_level;
        end else if (!gate && (state == S_ATTACK || state == S_DECAY || state == S_SUSTAIN)) begin
            state_nxt = S_RELEASE;
            level_nxt = rel_level;
        end else begin
            case (state)
                S_ATTACK: begin
                    level_nxt = atk_level;
                    if (atk_full) state_nxt = S_DECAY;
                end
                S_DECAY: begin
                    if (dec_done) begin
                        level_nxt = sustain_level;
                        state_nxt = S_SUSTAIN;
                    end else begin
                        level_nxt = env_level - decay_step;
                    end
                end
                S_SUSTAIN: level_nxt = sustain_level;
                S_RELEASE: begin
                    level_nxt = rel_level;
                    if (rel_done) state_nxt = S_IDLE;
                end
                default: begin
                    level_nxt = '0;
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Gain uses the post-update level; both operands widened so the product never truncates.
    assign smp   = in_valid ? in_sample : 16'sd0;
    assign smp_w = smp;
    assign lvl_w = signed'({17'b0, level_nxt});

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            gate_d     <= 1'b0;
            rise_seen  <= 1'b0;
            state      <= S_IDLE;
            env_level  <= '0;
            out_sample <= '0;
            out_valid  <= 1'b0;
        end else begin
            gate_d    <= gate;
            out_valid <= tick;
            if (tick) begin
                cnt        <= '0;
                rise_seen  <= 1'b0;
                state      <= state_nxt;
                env_level  <= level_nxt;
                out_sample <= 16'((lvl_w * smp_w) >>> LEVEL_BITS);
            end else begin
                cnt <= cnt + CNT_BITS'(1);
                if (rise) rise_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_envelope_gain_stage.sv
// Directed bench for envelope_gain_stage: vector table of per-tick inputs and expected
// envelope/output values, plus hand sequences for short gate pulses and async reset.
module tb_envelope_gain_stage;

    logic               mclk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] in_sample = '0;
    logic               in_valid = 1'b0;
    logic               gate = 1'b0;
    logic [15:0]        attack_step = '0, decay_step = '0, sustain_level = '0, release_step = '0;
    logic signed [15:0] out_sample;
    logic               out_valid;
    logic [15:0]        env_level;
    logic [2:0]         env_state;
    logic               busy;

    int checks = 0;
    int errors = 0;

    envelope_gain_stage #(.MCLK_PER_SAMPLE(256), .LEVEL_BITS(16)) dut (
        .mclk(mclk), .rst_n(rst_n), .in_sample(in_sample), .in_valid(in_valid), .gate(gate),
        .attack_step(attack_step), .decay_step(decay_step), .sustain_level(sustain_level),
        .release_step(release_step), .out_sample(out_sample), .out_valid(out_valid),
        .env_level(env_level), .env_state(env_state), .busy(busy)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic               g;
        logic signed [15:0] smp;
        logic               vld;
        logic [15:0]        atk, dec, sus, rel;
        logic [15:0]        exp_level;
        logic [2:0]         exp_state;
        logic signed [15:0] exp_out;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic g, logic signed [15:0] smp, logic vld, logic [15:0] atk,
                                logic [15:0] dec, logic [15:0] sus, logic [15:0] rel,
                                logic [15:0] lvl, logic [2:0] st, logic signed [15:0] o);
        vec_t v;
        v.g = g; v.smp = smp; v.vld = vld; v.atk = atk; v.dec = dec; v.sus = sus; v.rel = rel;
        v.exp_level = lvl; v.exp_state = st; v.exp_out = o;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Waits (bounded) for the next out_valid pulse; returns negedges waited.
    task automatic next_pulse(string name, output int n);
        n = 0;
        do begin
            @(negedge mclk);
            n++;
        end while (!out_valid && n < 400);
        check({name, "_pulse"}, int'(out_valid), 1);
    endtask

    task automatic check_tick(string name, logic [15:0] lvl, logic [2:0] st, logic signed [15:0] o);
        check({name, "_level"}, int'(env_level), int'(lvl));
        check({name, "_state"}, int'(env_state), int'(st));
        check({name, "_out"}, int'(out_sample), int'(o));
        check({name, "_busy"}, int'(busy), int'(st != 3'd0));
    endtask

    initial begin
        int n;
        logic [15:0] lvl;

        // Idle: no gate, samples present but silent envelope.
        for (int k = 0; k < 3; k++) add(0, 16'sd1000, 1, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 16'sd0);
        // Attack in 0x1000 steps, saturating at full scale on tick 16.
        for (int k = 1; k <= 16; k++) begin
            lvl = (k < 16) ? 16'(k * 32'h1000) : 16'hFFFF;
            add(1, 16'sd16384, 1, 16'h1000, 16'h0800, 16'h8000, 16'h4000,
                lvl, (k < 16) ? 3'd1 : 3'd2, signed'(lvl >> 2));
        end
        // Decay in 0x0800 steps, snapping onto sustain 0x8000.
        for (int k = 1; k <= 16; k++) begin
            lvl = (k < 16) ? 16'(32'hFFFF - k * 32'h0800) : 16'h8000;
            add(1, 16'sd16384, 1, 16'h1000, 16'h0800, 16'h8000, 16'h4000,
                lvl, (k < 16) ? 3'd2 : 3'd3, signed'(lvl >> 2));
        end
        add(1, -16'sd32768, 1, 16'h1000, 16'h0800, 16'h8000, 16'h4000, 16'h8000, 3'd3, -16'sd16384);
        add(1, -16'sd32768, 1, 16'h1000, 16'h0800, 16'h6000, 16'h4000, 16'h6000, 3'd3, -16'sd12288);
        add(1, 16'sd16384, 1, 16'h1000, 16'h0800, 16'h8000, 16'h4000, 16'h8000, 3'd3, 16'sd8192);
        // Release, legato retrigger mid-release, then release to idle.
        add(0, 16'sd16384, 1, 16'h1000, 16'h0800, 16'h8000, 16'h4000, 16'h4000, 3'd4, 16'sd4096);
        add(1, 16'sd16384, 1, 16'h1000, 16'h0800, 16'h8000, 16'h4000, 16'h5000, 3'd1, 16'sd5120);
        add(0, 16'sd16384, 1, 16'h1000, 16'h0800, 16'h8000, 16'h4000, 16'h1000, 3'd4, 16'sd1024);
        add(0, 16'sd16384, 1, 16'h1000, 16'h0800, 16'h8000, 16'h4000, 16'h0000, 3'd0, 16'sd0);
        add(0, 16'sd16384, 1, 16'h1000, 16'h0800, 16'h8000, 16'h4000, 16'h0000, 3'd0, 16'sd0);

        repeat (3) @(negedge mclk);
        check("reset_out_valid", int'(out_valid), 0);
        check_tick("reset", 16'h0, 3'd0, 16'sd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            gate = vecs[i].g; in_sample = vecs[i].smp; in_valid = vecs[i].vld;
            attack_step = vecs[i].atk; decay_step = vecs[i].dec;
            sustain_level = vecs[i].sus; release_step = vecs[i].rel;
            next_pulse($sformatf("v%0d", i), n);
            check($sformatf("v%0d_interval", i), n, 256);
            check_tick($sformatf("v%0d", i), vecs[i].exp_level, vecs[i].exp_state, vecs[i].exp_out);
        end

        // Short gate pulse between ticks, with in_valid low on the attack tick.
        repeat (10) @(negedge mclk);
        gate = 1'b1; in_sample = 16'sd5000; in_valid = 1'b0;
        repeat (3) @(negedge mclk);
        gate = 1'b0;
        next_pulse("short_atk", n);
        check_tick("short_atk", 16'h1000, 3'd1, 16'sd0);
        in_sample = 16'sd16384; in_valid = 1'b1;
        next_pulse("short_rel", n);
        check_tick("short_rel", 16'h0000, 3'd4, 16'sd0);
        next_pulse("short_idle", n);
        check_tick("short_idle", 16'h0000, 3'd0, 16'sd0);

        // Async reset in the middle of attack, while out_valid is high.
        gate = 1'b1;
        next_pulse("pre_rst", n);
        check_tick("pre_rst", 16'h1000, 3'd1, 16'sd1024);
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check_tick("rst_async", 16'h0, 3'd0, 16'sd0);
        gate = 1'b0;
        @(negedge mclk);
        rst_n = 1'b1;
        next_pulse("post_rst", n);
        check("post_rst_interval", n, 256);
        check_tick("post_rst", 16'h0, 3'd0, 16'sd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/envelope_gain_stage.md
Name: envelope_gain_stage

Overview:
- Per-voice ADSR amplitude envelope and gain stage, directly downstream of player_module.
- Consumes the raw player_sample/valid stream on mclk and produces an envelope-scaled signed 16-bit sample once per sample period, for the mixer/I2S path.
- Gate input (note on/off) drives a 5-state ADSR FSM updated at sample rate.

Parameters:
- MCLK_PER_SAMPLE, 256, mclk cycles per sample period; tick cadence (must be ≥ 2).
- LEVEL_BITS, 16, envelope level width, unsigned, full scale 2^LEVEL_BITS-1.

Ports:
- mclk, in, 1, master clock (256x sample rate).
- rst_n, in, 1, asynchronous active-low reset.
- in_sample, in, 16 (shortint), player sample.
- in_valid, in, 1, player valid; sample treated as 0 when low.
- gate, in, 1, note held high; rising edge = trigger/retrigger.
- attack_step, in, LEVEL_BITS, level increment per tick in ATTACK; 0 = instant.
- decay_step, in, LEVEL_BITS, decrement per tick in DECAY; 0 = instant.
- sustain_level, in, LEVEL_BITS, sustain target.
- release_step, in, LEVEL_BITS, decrement per tick in RELEASE; 0 = instant.
- out_sample, out, 16 (shortint), scaled sample.
- out_valid, out, 1, one-mclk pulse when out_sample updates.
- env_level, out, LEVEL_BITS, current envelope level.
- env_state, out, 3, IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4.
- busy, out, 1, env_state != IDLE.

Behaviour:
- Reset (rst_n low, async): tick counter 0, state IDLE, env_level 0, out_sample 0, out_valid 0, rise_seen 0, gate_d 0. Reset mid-note silences immediately; no release.
- Tick counter counts 0..MCLK_PER_SAMPLE-1 and wraps; tick = (count == MCLK_PER_SAMPLE-1). The first tick after reset is at cycle MCLK_PER_SAMPLE-1.
- gate is registered as gate_d every mclk. A rising edge (gate & ~gate_d) sets sticky rise_seen, which clears on tick.
- On tick, evaluated in priority order:
  1. rise_seen, or an edge detected in the tick cycle itself → ATTACK; apply one attack step this tick from the current level, with no reset to 0 (retrigger is legato).
  2. else gate low and state ∈ {ATTACK, DECAY, SUSTAIN} → RELEASE; apply one release step this tick.
  3. else per-state update:
     - ATTACK: level = min(level + attack_step, FS); on reaching FS → DECAY. attack_step 0 → level = FS, → DECAY.
     - DECAY: if level ≤ sustain_level + decay_step, or decay_step 0 → level = sustain_level, → SUSTAIN; else level -= decay_step.
     - SUSTAIN: level = sustain_level, tracking live changes.
     - RELEASE: if level ≤ release_step, or release_step 0 → level = 0, → IDLE; else level -= release_step.
     - IDLE: level stays 0.
- Short gate pulse between ticks: ATTACK on the next tick, then RELEASE on the following tick.
- Arithmetic: additions are computed in LEVEL_BITS+1 bits and saturate, never wrapping.
- Gain: in the tick cycle, capture s = in_valid ? in_sample : 0.
  - The product uses the post-update level: signed 17-bit {0,level} × signed 16-bit s → 33-bit.
  - out_sample = product >>> LEVEL_BITS (arithmetic shift, floor), registered.
  - out_valid = 1 for exactly the cycle after the tick. Latency is 1 mclk from tick to out_valid.
  - Range: -32768×65535 >>> 16 = -32768, so no overflow is possible.
- out_sample holds its value between pulses. env_level and env_state change only at tick edges.

Test Plan:
- Reset then idle, gate 0, in_sample 1000 for 3 ticks → out_valid pulses every 256 mclks, out_sample 0, env_state 0, busy 0.
- attack_step 0x1000, gate rises → env_level 0x1000, 0x2000, … reaches 0xFFFF at tick 16, env_state → 2 on that tick, no wrap.
- decay_step 0x0800, sustain_level 0x8000 → level falls from 0xFFFF in 0x0800 steps, lands exactly on 0x8000 and enters SUSTAIN. in_sample 16384 → out_sample 8192; in_sample -32768 → -16384.
- In SUSTAIN, drop gate with release_step 0x4000 → levels 0x4000, 0x0000, then IDLE, busy 0. Raise gate again mid-release at level 0x4000 → ATTACK continues from 0x4000 (0x5000 with attack_step 0x1000).
- Gate high for 3 mclks between ticks → next tick ATTACK with level = attack_step, following tick RELEASE.
- Assert rst_n low mid-ATTACK → out_sample, env_level, out_valid 0 asynchronously. in_valid low at tick with in_sample 5000 → out_sample 0.
